// File: rtl/indirect_residual_gate_if.sv
`default_nettype none
// ============================================================================
//  Module   : indirect_residual_gate_if
//  Brief    : Sample/reprojection input bus, residual FIFO output bus and
//             frame status for indirect_residual_gate.
//  Revision : 1.0  initial release
// ============================================================================
interface indirect_residual_gate_if #(
  parameter int H_BW   = 11,
  parameter int V_BW   = 10,
  parameter int OUT_BW = 42,
  parameter int CNT_BW = 16
);
  logic              i_frame_start;
  logic              i_frame_end;
  logic              i_valid;
  logic [H_BW-1:0]   i_idx1_x;
  logic [V_BW-1:0]   i_idx1_y;
  logic              i_proj_valid;
  logic [H_BW-1:0]   i_proj_x;
  logic [V_BW-1:0]   i_proj_y;
  logic [H_BW-1:0]   r_thresh;
  logic              r_gate_en;
  logic              o_valid;
  logic              i_ready;
  logic [OUT_BW-1:0] o_diffs_x;
  logic [OUT_BW-1:0] o_diffs_y;
  logic              o_inlier;
  logic              o_frame_end;
  logic              o_done;
  logic [CNT_BW-1:0] o_inlier_cnt;
  logic              o_overflow;
  logic              o_align_err;

  modport master (
    output i_frame_start, i_frame_end, i_valid, i_idx1_x, i_idx1_y,
           i_proj_valid, i_proj_x, i_proj_y, r_thresh, r_gate_en, i_ready,
    input  o_valid, o_diffs_x, o_diffs_y, o_inlier, o_frame_end, o_done,
           o_inlier_cnt, o_overflow, o_align_err
  );

  modport slave (
    input  i_frame_start, i_frame_end, i_valid, i_idx1_x, i_idx1_y,
           i_proj_valid, i_proj_x, i_proj_y, r_thresh, r_gate_en, i_ready,
    output o_valid, o_diffs_x, o_diffs_y, o_inlier, o_frame_end, o_done,
           o_inlier_cnt, o_overflow, o_align_err
  );
endinterface
`default_nettype wire

// File: rtl/indirect_residual_gate.sv
`default_nettype none
// ============================================================================
//  Module   : indirect_residual_gate
//  Brief    : Aligns idx1 with reprojected points, gates outlier residuals,
//             counts inliers per frame and buffers results in a FWFT FIFO.
//  Revision : 1.0  initial release
// ============================================================================
module indirect_residual_gate #(
  parameter int H_BW       = 11,
  parameter int V_BW       = 10,
  parameter int PROJ_LAT   = 11,
  parameter int OUT_BW     = 42,
  parameter int FRAC       = 20,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_BW     = 16
) (
  input wire                       i_clk,
  input wire                       i_rst,
  indirect_residual_gate_if.slave  bus
);

  localparam int DX_BW  = H_BW + 1;
  localparam int DY_BW  = V_BW + 1;
  localparam int EXT_BW = OUT_BW - FRAC;
  localparam int AW     = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic            v;
    logic            fs;
    logic            fe;
    logic [H_BW-1:0] x;
    logic [V_BW-1:0] y;
  } dl_t;

  typedef struct packed {
    logic             fe;
    logic             inl;
    logic [DX_BW-1:0] dx;
    logic [DY_BW-1:0] dy;
  } fifo_t;

  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DRAIN = 2'd2} state_t;

  // Alignment delay line for idx1 and its frame flags
  dl_t dl_q [PROJ_LAT];
  dl_t dl_d [PROJ_LAT];
  dl_t dl_tail;

  always_comb begin
    dl_d[0].v  = bus.i_valid;
    dl_d[0].fs = bus.i_frame_start;
    dl_d[0].fe = bus.i_frame_end;
    dl_d[0].x  = bus.i_idx1_x;
    dl_d[0].y  = bus.i_idx1_y;
    for (int i = 1; i < PROJ_LAT; i++) dl_d[i] = dl_q[i-1];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < PROJ_LAT; i++) dl_q[i] <= '0;
    end else begin
      for (int i = 0; i < PROJ_LAT; i++) dl_q[i] <= dl_d[i];
    end
  end

  assign dl_tail = dl_q[PROJ_LAT-1];

  // Residual stage: zero-extended subtraction cannot wrap
  logic [DX_BW-1:0] dx_w, adx_w;
  logic [DY_BW-1:0] dy_w, ady_w;
  logic             inl_w;

  always_comb begin
    dx_w  = {1'b0, dl_tail.x} - {1'b0, bus.i_proj_x};
    dy_w  = {1'b0, dl_tail.y} - {1'b0, bus.i_proj_y};
    adx_w = dx_w[DX_BW-1] ? (~dx_w + 1'b1) : dx_w;
    ady_w = dy_w[DY_BW-1] ? (~dy_w + 1'b1) : dy_w;
    inl_w = (adx_w <= {1'b0, bus.r_thresh}) &&
            (DX_BW'(ady_w) <= {1'b0, bus.r_thresh});
  end

  logic             rv_q, rfs_q, rfe_q, rin_q;
  logic [DX_BW-1:0] rdx_q;
  logic [DY_BW-1:0] rdy_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rv_q  <= 1'b0;
      rfs_q <= 1'b0;
      rfe_q <= 1'b0;
      rin_q <= 1'b0;
      rdx_q <= '0;
      rdy_q <= '0;
    end else begin
      rv_q  <= dl_tail.v;
      rfs_q <= dl_tail.fs;
      rfe_q <= dl_tail.fe;
      rin_q <= inl_w;
      rdx_q <= dx_w;
      rdy_q <= dy_w;
    end
  end

  // FIFO and frame control
  state_t            state_q, state_d;
  logic              pend_q, pend_d;
  logic              done_q, done_d;
  logic              fe_lost_q, fe_lost_d;
  logic              ovf_q, ovf_d;
  logic              aerr_q, aerr_d;
  logic [CNT_BW-1:0] cnt_q, cnt_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       fcnt_q, fcnt_d;
  fifo_t             mem_q [FIFO_DEPTH];
  fifo_t             head_w, push_data_w;
  logic              empty_w, full_w, pop_w, push_req_w, push_ok_w;

  always_comb begin
    head_w      = mem_q[rd_ptr_q];
    empty_w     = (fcnt_q == '0);
    full_w      = (fcnt_q == (AW+1)'(FIFO_DEPTH));
    pop_w       = !empty_w && bus.i_ready;
    // Frame-end samples bypass the gate so the end marker reaches the consumer
    push_req_w  = rv_q && ((state_q != IDLE) || rfs_q) &&
                  (rin_q || !bus.r_gate_en || rfe_q);
    push_ok_w   = push_req_w && (!full_w || pop_w);
    push_data_w = '{fe: rfe_q, inl: rin_q, dx: rdx_q, dy: rdy_q};
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fcnt_d   = fcnt_q;
    ovf_d    = ovf_q | (push_req_w & ~push_ok_w);
    aerr_d   = aerr_q | (dl_tail.v ^ bus.i_proj_valid);
    if (push_ok_w) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_w)     rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok_w, pop_w})
      2'b10:   fcnt_d = fcnt_q + 1'b1;
      2'b01:   fcnt_d = fcnt_q - 1'b1;
      default: fcnt_d = fcnt_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    fe_lost_d = fe_lost_q | (push_req_w & rfe_q & ~push_ok_w);
    unique case (state_q)
      IDLE: begin
        if (rv_q && rfs_q) begin
          cnt_d   = CNT_BW'(rin_q);
          state_d = rfe_q ? DRAIN : ACTIVE;
        end
      end
      ACTIVE: begin
        if (rv_q) begin
          if (rfs_q)                      cnt_d = CNT_BW'(rin_q);
          else if (rin_q && cnt_q != '1)  cnt_d = cnt_q + 1'b1;
          if (rfe_q)                      state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (rv_q && rfs_q) pend_d = 1'b1;
        // A lost end marker still completes the frame once the FIFO runs dry
        if ((pop_w && head_w.fe) || (fe_lost_q && empty_w)) begin
          done_d    = 1'b1;
          fe_lost_d = 1'b0;
          if (pend_d) begin
            state_d = ACTIVE;
            cnt_d   = '0;
            pend_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      pend_q    <= 1'b0;
      done_q    <= 1'b0;
      fe_lost_q <= 1'b0;
      ovf_q     <= 1'b0;
      aerr_q    <= 1'b0;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      done_q    <= done_d;
      fe_lost_q <= fe_lost_d;
      ovf_q     <= ovf_d;
      aerr_q    <= aerr_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fcnt_q    <= fcnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok_w) mem_q[wr_ptr_q] <= push_data_w;
  end

  // Head fields are masked while empty so stale storage never reaches the port
  assign bus.o_valid      = !empty_w;
  assign bus.o_diffs_x    = empty_w ? '0 :
                            {{(EXT_BW-DX_BW){head_w.dx[DX_BW-1]}}, head_w.dx, {FRAC{1'b0}}};
  assign bus.o_diffs_y    = empty_w ? '0 :
                            {{(EXT_BW-DY_BW){head_w.dy[DY_BW-1]}}, head_w.dy, {FRAC{1'b0}}};
  assign bus.o_inlier     = !empty_w && head_w.inl;
  assign bus.o_frame_end  = !empty_w && head_w.fe;
  assign bus.o_done       = done_q;
  assign bus.o_inlier_cnt = cnt_q;
  assign bus.o_overflow   = ovf_q;
  assign bus.o_align_err  = aerr_q;

endmodule
`default_nettype wire
